// File: rtl/pc_sequencer.sv
// Program counter / EPC owner for the multicycle CPU: resolves next-PC requests
// into the mux_PC select and runs the exception-entry sequence.
module pc_sequencer #(
  parameter logic [31:0] EXC_BASE = 32'd253,
  parameter logic [31:0] PC_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_seq,
  input  logic        req_branch,
  input  logic        req_jump,
  input  logic        req_jr,
  input  logic        req_rte,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_byte,
  input  logic [31:0] pc_next,
  output logic [2:0]  muxPCcontrol,
  output logic [31:0] vector_out,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [31:0] exc_addr,
  output logic        exc_read,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXC_RD   = 2'd1,
    EXC_WAIT = 2'd2,
    EXC_LOAD = 2'd3
  } state_t;

  localparam logic [2:0] SEL_EPC    = 3'b000;
  localparam logic [2:0] SEL_VECTOR = 3'b001;
  localparam logic [2:0] SEL_ALUOUT = 3'b010;
  localparam logic [2:0] SEL_CONCAT = 3'b011;
  localparam logic [2:0] SEL_ALURES = 3'b100;

  state_t      state_reg;
  logic [1:0]  code_reg;
  logic [31:0] pc_reg;
  logic [31:0] epc_reg;
  logic [31:0] vector_reg;
  logic [31:0] exc_addr_reg;
  logic        exc_read_reg;

  logic        any_req;
  logic        pc_we;
  logic [2:0]  sel_next;

  assign any_req = req_seq | req_branch | req_jump | req_jr | req_rte;

  // The mux select must be valid in the same cycle the PC is written from it.
  always_comb begin
    sel_next = SEL_ALURES;
    pc_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (exc_code == 2'b00) begin
          pc_we = any_req;
          if (req_rte)         sel_next = SEL_EPC;
          else if (req_jr)     sel_next = SEL_ALURES;
          else if (req_jump)   sel_next = SEL_CONCAT;
          else if (req_branch) sel_next = SEL_ALUOUT;
          else                 sel_next = SEL_ALURES;
        end
      end
      EXC_LOAD: begin
        sel_next = SEL_VECTOR;
        pc_we    = 1'b1;
      end
      default: begin
        sel_next = SEL_ALURES;
        pc_we    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      code_reg     <= 2'b00;
      pc_reg       <= PC_RESET;
      epc_reg      <= 32'd0;
      vector_reg   <= 32'd0;
      exc_addr_reg <= 32'd0;
      exc_read_reg <= 1'b0;
    end else begin
      if (pc_we) pc_reg <= pc_next;
      case (state_reg)
        IDLE: begin
          if (exc_code != 2'b00) begin
            epc_reg      <= pc_reg - 32'd4;
            code_reg     <= exc_code;
            // Address and strobe are registered so they are stable throughout EXC_RD.
            exc_addr_reg <= EXC_BASE + {30'd0, exc_code} - 32'd1;
            exc_read_reg <= 1'b1;
            state_reg    <= EXC_RD;
          end
        end
        EXC_RD: begin
          exc_read_reg <= 1'b0;
          state_reg    <= EXC_WAIT;
        end
        EXC_WAIT: begin
          vector_reg <= {24'd0, mem_byte};
          state_reg  <= EXC_LOAD;
        end
        EXC_LOAD: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign muxPCcontrol = sel_next;
  assign vector_out   = vector_reg;
  assign pc_out       = pc_reg;
  assign epc_out      = epc_reg;
  assign exc_addr     = exc_addr_reg;
  assign exc_read     = exc_read_reg;
  assign busy         = (state_reg != IDLE);

endmodule
